sram_access_arbiter: RTL and testbench



---
 rtl/sram_access_arbiter.sv | 117 +++++++++++
 tb/tb_sram_access_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sram_access_arbiter.sv
// sram_access_arbiter: sequences recorder writes and player reads onto one 256K x 16 SRAM.
// Define SRAM_ARB_WR_PRIORITY_EN for fixed write priority instead of round-robin.
module sram_access_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        bclk,
   input  logic        rst,
   input  logic        wr_req,
   input  logic [17:0] wr_addr,
   input  logic [15:0] wr_data,
   output logic        wr_ack,
   input  logic        rd_req,
   input  logic [17:0] rd_addr,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_o,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_i,
   output logic        sram_ce_n,
   output logic        sram_we_n,
   output logic        sram_oe_n,
   output logic        sram_ub_n,
   output logic        sram_lb_n
);
   typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_DONE, R_SETUP, R_WAIT, R_LATCH} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [17:0] addr_q, addr_d;
   logic [15:0] dq_o_q, dq_o_d, rd_data_q, rd_data_d;
   logic        dq_oe_q, dq_oe_d, ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
   logic        ack_q, ack_d, valid_q, valid_d;
   logic        grant_wr;

`ifdef SRAM_ARB_WR_PRIORITY_EN
   assign grant_wr = wr_req;
`else
   logic last_wr_q, last_wr_d;
   // a tie goes to whichever side did not win the previous grant
   assign grant_wr  = wr_req & (~rd_req | ~last_wr_q);
   assign last_wr_d = state_d == W_SETUP ? 1'b1 : state_d == R_SETUP ? 1'b0 : last_wr_q;
   always_ff @(posedge bclk) last_wr_q <= rst ? 1'b0 : last_wr_d;
`endif

   always_ff @(posedge bclk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         dq_o_q    <= '0;
         rd_data_q <= '0;
         dq_oe_q   <= 1'b0;
         ce_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         ack_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         dq_o_q    <= dq_o_d;
         rd_data_q <= rd_data_d;
         dq_oe_q   <= dq_oe_d;
         ce_n_q    <= ce_n_d;
         we_n_q    <= we_n_d;
         oe_n_q    <= oe_n_d;
         ack_q     <= ack_d;
         valid_q   <= valid_d;
      end
   end

   // counter is loaded leaving a SETUP state and exits the hold state at zero
   always_comb begin
      state_d = state_q;
      cnt_d   = (state_q == W_SETUP || state_q == R_SETUP) ? 4'(WAIT_CYCLES - 1)
                                                           : cnt_q - {3'b000, cnt_q != 4'd0};
      unique case (state_q)
         IDLE:    state_d = grant_wr ? W_SETUP : rd_req ? R_SETUP : IDLE;
         W_SETUP: state_d = W_PULSE;
         W_PULSE: state_d = cnt_q == 4'd0 ? W_DONE : W_PULSE;
         W_DONE:  state_d = IDLE;
         R_SETUP: state_d = R_WAIT;
         R_WAIT:  state_d = cnt_q == 4'd0 ? R_LATCH : R_WAIT;
         R_LATCH: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // outputs are decoded from the next state so every pin comes straight from a flop
   always_comb begin
      addr_d    = state_d == W_SETUP ? wr_addr : state_d == R_SETUP ? rd_addr : addr_q;
      dq_o_d    = state_d == W_SETUP ? wr_data : dq_o_q;
      rd_data_d = state_d == R_LATCH ? sram_dq_i : rd_data_q;
      dq_oe_d   = state_d inside {W_SETUP, W_PULSE, W_DONE};
      ce_n_d    = state_d == IDLE;
      we_n_d    = state_d != W_PULSE;
      oe_n_d    = !(state_d inside {R_SETUP, R_WAIT});
      ack_d     = state_d == W_DONE;
      valid_d   = state_d == R_LATCH;
   end

   assign wr_ack     = ack_q;
   assign rd_valid   = valid_q;
   assign rd_data    = rd_data_q;
   assign busy       = ~ce_n_q;
   assign sram_addr  = addr_q;
   assign sram_dq_o  = dq_o_q;
   assign sram_dq_oe = dq_oe_q;
   assign sram_ce_n  = ce_n_q;
   assign sram_we_n  = we_n_q;
   assign sram_oe_n  = oe_n_q;
   assign sram_ub_n  = ce_n_q;
   assign sram_lb_n  = ce_n_q;
endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb_sram_access_arbiter: two arbiters (WAIT_CYCLES 1 and 3) against a cycle-schedule reference model.
module tb_sram_access_arbiter;
   logic bclk = 1'b0;
   int   n_cmp = 0, n_bad = 0, done = 0;

   always #5 bclk = ~bclk;

   task automatic check(input int w, input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL W=%0d %s: got %0h, expected %0h", w, tag, got, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int W = g == 0 ? 1 : 3;
      logic        rst, wr_req, rd_req, wr_ack, rd_valid, busy, dq_oe, ce_n, we_n, oe_n, ub_n, lb_n;
      logic [17:0] wr_addr, rd_addr, sram_addr;
      logic [15:0] wr_data, rd_data, dq_o, dq_i;
      logic [15:0] sram [262144];
      logic [15:0] ref_mem [int];
      logic [17:0] pool [8] = '{18'h00000, 18'h3FFFF, 18'h00010, 18'h12345,
                                18'h2AAAA, 18'h15555, 18'h00001, 18'h3FFFE};
      logic [33:0] wq [$];
      logic [17:0] rq [$];
      int          t, t0, ph, n;
      bit          op_w, last_w, acc;
      logic [17:0] m_addr;
      logic [15:0] m_data, exp_rd, last_rd;

      sram_access_arbiter #(.WAIT_CYCLES(W)) dut (
         .bclk(bclk), .rst(rst),
         .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
         .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
         .busy(busy), .sram_addr(sram_addr), .sram_dq_o(dq_o), .sram_dq_oe(dq_oe),
         .sram_dq_i(dq_i), .sram_ce_n(ce_n), .sram_we_n(we_n), .sram_oe_n(oe_n),
         .sram_ub_n(ub_n), .sram_lb_n(lb_n)
      );

      always @(posedge bclk) if (!ce_n && !we_n) sram[sram_addr] <= dq_o;
      assign dq_i = (!ce_n && !oe_n) ? sram[sram_addr] : 16'h0000;

      // an access granted in cycle t0 occupies t0+1 .. t0+2+W; the next grant can happen at t0+3+W
      task automatic decide();
         bit gw;
         if (rst) begin
            t0 = -100;
            last_w = 1'b0;
            last_rd = '0;
         end else if (t - t0 > 2 + W) begin
`ifdef SRAM_ARB_WR_PRIORITY_EN
            gw = wr_req;
`else
            gw = wr_req && (!rd_req || !last_w);
`endif
            if (gw) begin
               t0 = t; op_w = 1'b1; last_w = 1'b1; m_addr = wr_addr; m_data = wr_data;
               ref_mem[int'(wr_addr)] = wr_data;
            end else if (rd_req) begin
               t0 = t; op_w = 1'b0; last_w = 1'b0; m_addr = rd_addr;
               exp_rd = ref_mem.exists(int'(rd_addr)) ? ref_mem[int'(rd_addr)] : 16'h0000;
            end
         end
      endtask

      task automatic cyc();
         decide();
         @(posedge bclk);
         #1;
         t++;
         ph  = t - t0;
         acc = ph >= 1 && ph <= 2 + W;
         check(W, "busy", busy, acc);
         check(W, "ce_n", ce_n, !acc);
         check(W, "ub_lb", {ub_n, lb_n}, {2{!acc}});
         check(W, "wr_ack", wr_ack, acc && op_w && ph == 2 + W);
         check(W, "rd_valid", rd_valid, acc && !op_w && ph == 2 + W);
         check(W, "we_n", we_n, !(op_w && ph >= 2 && ph <= 1 + W));
         check(W, "oe_n", oe_n, !(!op_w && ph >= 1 && ph <= 1 + W));
         check(W, "dq_oe", dq_oe, acc && op_w);
         check(W, "bus_safe", dq_oe && !oe_n, 1'b0);
         if (acc) check(W, "sram_addr", sram_addr, m_addr);
         if (acc && op_w) check(W, "dq_o", dq_o, m_data);
         if (acc && !op_w && ph == 2 + W) last_rd = exp_rd;
         check(W, "rd_data", rd_data, last_rd);
         if (wr_ack) wr_req = 1'b0;
         if (!wr_req && !rst && wq.size() > 0) begin
            {wr_addr, wr_data} = wq.pop_front();
            wr_req = 1'b1;
         end
         if (rd_valid) rd_req = 1'b0;
         if (!rd_req && !rst && rq.size() > 0) begin
            rd_addr = rq.pop_front();
            rd_req = 1'b1;
         end
      endtask

      task automatic drain();
         int k = 0;
         while ((wr_req || rd_req || wq.size() > 0 || rq.size() > 0 || t - t0 <= 2 + W) && k < 300) begin
            cyc();
            k++;
         end
         check(W, "drain_timeout", k < 300, 1'b1);
      endtask

      initial begin
         rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
         t = 0; t0 = -100; op_w = 1'b0; last_w = 1'b0; m_addr = '0; m_data = '0; exp_rd = '0; last_rd = '0;
         repeat (2) cyc();
         check(W, "rst_sram_addr", sram_addr, 18'h0);
         check(W, "rst_dq_o", dq_o, 16'h0);
         rst = 1'b0;
         wq.push_back({18'h00010, 16'hA5A5});
         drain();
         rq.push_back(18'h00010);
         drain();
         wq.push_back({18'h3FFFF, 16'h1111});
         wq.push_back({18'h00000, 16'h2222});
         wq.push_back({18'h00010, 16'h3333});
         rq.push_back(18'h00010);
         rq.push_back(18'h3FFFF);
         drain();
         wq.push_back({18'h3FFFF, 16'hBEEF});
         wq.push_back({18'h00000, 16'hCAFE});
         drain();
         rq.push_back(18'h3FFFF);
         rq.push_back(18'h00000);
         drain();
         wq.push_back({18'h00020, 16'h5A5A});
         n = 0;
         while (we_n !== 1'b0 && n < 20) begin
            cyc();
            n++;
         end
         check(W, "pulse_seen", we_n, 1'b0);
         rst = 1'b1;
         wr_req = 1'b0;
         cyc();
         rst = 1'b0;
         cyc();
         wq.push_back({18'h00020, 16'h6B6B});
         rq.push_back(18'h00020);
         drain();
         for (int i = 0; i < 600; i++) begin
            int k = $urandom_range(7);
            if (wq.size() < 2 && $urandom_range(3) == 0) wq.push_back({pool[k], 16'($urandom)});
            k = $urandom_range(7);
            if (rq.size() < 2 && ref_mem.exists(int'(pool[k])) && $urandom_range(3) == 0) rq.push_back(pool[k]);
            cyc();
         end
         drain();
         done++;
      end
   end

   initial begin
      for (int i = 0; i < 60000 && done < 2; i++) @(posedge bclk);
      check(0, "sim_timeout", done, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
